// File: rtl/key_search_if.sv
// ---------------------------------------------------------------------------
// key_search_if
//   Bundles the signals of the key search controller: the search request, the
//   table read port, the Comparator connection and the result.
//   slave  : controller side (key_search_ctrl)
//   master : environment side (requester, table memory, Comparator)
// Signals
//   start, key            search request and key
//   mem_addr, mem_rd      registered table read address / strobe
//   mem_data              table read data, valid the cycle after mem_rd
//   cmp_i1, cmp_i2        Comparator operands (latched key, table entry)
//   cmp_en, cmp_o         Comparator enable and its combinational match result
//   busy, done            search in progress / one-cycle completion pulse
//   found, match_addr     held result of the last completed search
// ---------------------------------------------------------------------------
interface key_search_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
);
   logic              start;
   logic [WIDTH-1:0]  key;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [WIDTH-1:0]  mem_data;
   logic [WIDTH-1:0]  cmp_i1;
   logic [WIDTH-1:0]  cmp_i2;
   logic              cmp_en;
   logic              cmp_o;
   logic              busy;
   logic              done;
   logic              found;
   logic [ADDR_W-1:0] match_addr;

   modport slave (
      input  start, key, mem_data, cmp_o,
      output mem_addr, mem_rd, cmp_i1, cmp_i2, cmp_en,
             busy, done, found, match_addr
   );

   modport master (
      output start, key, mem_data, cmp_o,
      input  mem_addr, mem_rd, cmp_i1, cmp_i2, cmp_en,
             busy, done, found, match_addr
   );
endinterface

// File: rtl/key_search_ctrl.sv
// ---------------------------------------------------------------------------
// key_search_ctrl
//   Sequential search controller in front of a Comparator. Latches a key on
//   START, then walks a synchronous-read table: FETCH issues the read, COMPARE
//   sees the entry on MEM_DATA and samples the Comparator result. Stops at the
//   first match or after entry DEPTH-1 and reports FOUND / MATCH_ADDR with a
//   one-cycle DONE pulse. Two cycles per entry.
// Parameters
//   WIDTH   key / entry width (equal to the Comparator width)
//   ADDR_W  table address width
//   DEPTH   entries searched, 1 <= DEPTH <= 2**ADDR_W
// Ports
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset; aborts a search, clears result
//   bus     key_search_if slave modport (request, table, Comparator, result)
// ---------------------------------------------------------------------------
module key_search_ctrl #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   key_search_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, FETCH, COMPARE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state_q;
   logic [WIDTH-1:0]  key_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] match_q;
   logic              rd_q;
   logic              en_q;
   logic              busy_q;
   logic              done_q;
   logic              found_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         key_q   <= '0;
         addr_q  <= '0;
         match_q <= '0;
         rd_q    <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         found_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // also taken in the DONE cycle, which gives back-to-back searches
               if (bus.start) begin
                  key_q   <= bus.key;
                  addr_q  <= '0;
                  found_q <= 1'b0;
                  match_q <= '0;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               rd_q    <= 1'b0;
               en_q    <= 1'b1;
               state_q <= COMPARE;
            end
            COMPARE: begin
               en_q <= 1'b0;
               if (bus.cmp_o) begin
                  found_q <= 1'b1;
                  match_q <= addr_q;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (addr_q == LAST) begin
                  // end at DEPTH-1 rather than relying on counter wrap
                  found_q <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  rd_q    <= 1'b1;
                  state_q <= FETCH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr   = addr_q;
   assign bus.mem_rd     = rd_q;
   assign bus.cmp_i1     = key_q;
   assign bus.cmp_i2     = bus.mem_data;
   assign bus.cmp_en     = en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.found      = found_q;
   assign bus.match_addr = match_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_search_ctrl
//   Two controller instances (DEPTH=16 and DEPTH=10) with behavioural table
//   memories and Comparators. Expected results are queued when a search is
//   started and popped when DONE appears.
// ---------------------------------------------------------------------------
module tb_key_search_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   key_search_if #(.WIDTH(8), .ADDR_W(4)) ifa ();
   key_search_if #(.WIDTH(8), .ADDR_W(4)) ifb ();

   key_search_ctrl #(.WIDTH(8), .ADDR_W(4), .DEPTH(16)) dut_a (
      .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
   key_search_ctrl #(.WIDTH(8), .ADDR_W(4), .DEPTH(10)) dut_b (
      .clk_i(clk), .rst_i(rst), .bus(ifb.slave));

   logic [7:0] mem_a [16];
   logic [7:0] mem_b [16];

   // synchronous-read tables
   always @(posedge clk) if (ifa.mem_rd) ifa.mem_data <= mem_a[ifa.mem_addr];
   always @(posedge clk) if (ifb.mem_rd) ifb.mem_data <= mem_b[ifb.mem_addr];

   // Comparator models
   assign ifa.cmp_o = ifa.cmp_en && (ifa.cmp_i1 == ifa.cmp_i2);
   assign ifb.cmp_o = ifb.cmp_en && (ifb.cmp_i1 == ifb.cmp_i2);

   int cyc = 0;
   int pulses_a = 0;
   int pulses_b = 0;
   logic [3:0] last_b = '0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ifa.cmp_en) pulses_a <= pulses_a + 1;
      if (ifb.cmp_en) pulses_b <= pulses_b + 1;
      if (ifb.mem_rd) last_b <= ifb.mem_addr;
   end

   typedef struct {
      bit         sel;
      logic       found;
      logic [3:0] addr;
      int         lat;
      int         e0;
      int         p0;
   } exp_t;
   exp_t sb[$];

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_addr"},  ifa.mem_addr,   0);
      check({tag, "_rd"},    ifa.mem_rd,     0);
      check({tag, "_en"},    ifa.cmp_en,     0);
      check({tag, "_busy"},  ifa.busy,       0);
      check({tag, "_done"},  ifa.done,       0);
      check({tag, "_found"}, ifa.found,      0);
      check({tag, "_match"}, ifa.match_addr, 0);
      check({tag, "_key"},   ifa.cmp_i1,     0);
   endtask

   // drive a one-cycle START and queue the expected outcome
   task automatic start_search(input bit sel, input logic [7:0] k,
                               input logic f, input logic [3:0] a, input int lat);
      exp_t e;
      if (sel) begin ifb.key = k; ifb.start = 1'b1; end
      else     begin ifa.key = k; ifa.start = 1'b1; end
      @(posedge clk); #1;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      e.sel = sel; e.found = f; e.addr = a; e.lat = lat;
      e.e0 = cyc; e.p0 = sel ? pulses_b : pulses_a;
      sb.push_back(e);
   endtask

   // wait (bounded) for DONE, then compare against the oldest expectation
   task automatic wait_done(input string tag);
      exp_t e;
      int   n;
      bit   seen;
      e = sb.pop_front();
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk); #1;
         n++;
         seen = e.sel ? ifb.done : ifa.done;
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_latency"}, cyc - e.e0, e.lat);
         check({tag, "_found"}, e.sel ? ifb.found : ifa.found, e.found);
         check({tag, "_match"}, e.sel ? ifb.match_addr : ifa.match_addr, e.addr);
         check({tag, "_pulses"}, (e.sel ? pulses_b : pulses_a) - e.p0, e.lat / 2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 8'h10 + 8'(i);
         mem_b[i] = 8'h20 + 8'(i);
      end
      mem_a[3] = 8'h5A;
      mem_a[9] = 8'h10;   // second copy of entry 0's value
      ifa.start = 1'b0; ifa.key = '0;
      ifb.start = 1'b0; ifb.key = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      check("reset_b_busy", ifb.busy, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: match at entry 3
      start_search(0, 8'h5A, 1, 3, 8);
      check("t1_busy", ifa.busy, 1);
      check("t1_rd", ifa.mem_rd, 1);
      check("t1_addr0", ifa.mem_addr, 0);
      check("t1_key", ifa.cmp_i1, 8'h5A);
      wait_done("t1");
      @(posedge clk); #1;
      check("t1_done_pulse", ifa.done, 0);
      check("t1_found_held", ifa.found, 1);
      check("t1_match_held", ifa.match_addr, 3);
      check("t1_idle", ifa.busy, 0);

      // 2: key absent, full sweep; previous result must be cleared
      start_search(0, 8'hFF, 0, 0, 32);
      wait_done("t2");
      check("t2_last_addr", ifa.mem_addr, 15);
      @(posedge clk); #1;

      // 3: first of two matches wins
      start_search(0, 8'h10, 1, 0, 2);
      wait_done("t3");
      @(posedge clk); #1;

      // match on the last entry
      start_search(0, 8'h1F, 1, 15, 32);
      wait_done("tlast");
      @(posedge clk); #1;

      // 4: START/KEY while busy ignored, then START in the DONE cycle
      start_search(0, 8'h5A, 1, 3, 8);
      @(posedge clk); #1;
      ifa.start = 1'b1; ifa.key = 8'h10;
      @(posedge clk); #1;
      ifa.start = 1'b0; ifa.key = 8'h77;
      check("t4_key_kept", ifa.cmp_i1, 8'h5A);
      wait_done("t4a");
      start_search(0, 8'h15, 1, 5, 12);
      wait_done("t4b");
      @(posedge clk); #1;

      // 5: reset during COMPARE at address 5
      ifa.key = 8'hFF; ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("t5_en", ifa.cmp_en, 1);
      check("t5_addr", ifa.mem_addr, 5);
      rst = 1'b1;
      #1;
      check_zero("t5_abort");
      @(posedge clk); #1;
      check("t5_no_done", ifa.done, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("t5_still_idle", ifa.done, 0);
      start_search(0, 8'h5A, 1, 3, 8);
      check("t5_restart_addr", ifa.mem_addr, 0);
      wait_done("t5");

      // 6: DEPTH=10, key only present beyond the searched range
      start_search(1, 8'h2C, 0, 0, 20);
      wait_done("t6");
      check("t6_last_addr", last_b, 9);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
